// File: rtl/dec_key_pkg.sv
// Shared types and width helpers for the serial unlock decoder.
package dec_key_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEY     = 3'd1,
    S_MODE    = 3'd2,
    S_ARMED   = 3'd3,
    S_ACTIVE  = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] DEFAULT_KEY_VALUE = 4'b1010;

  // Bit counter must reach the longer of the key and mode fields.
  function automatic int cnt_width(input int key_len, input int mode_w);
    int longest;
    longest = (key_len > mode_w) ? key_len : mode_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/dec_key_timer.sv
// Loadable down-counter: load restarts it at CYCLES-1, done is high once it reaches zero.
module dec_key_timer #(
  parameter int CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  output logic done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)               count <= '0;
    else if (load)           count <= LOAD_VAL;
    else if (count != '0)    count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/dec_input_key_seq.sv
// Serial unlock decoder: key compare, mode capture, Busy-gated activation,
// failed-attempt lockout, inter-bit timeout and relock.
module dec_input_key_seq
  import dec_key_pkg::*;
#(
  parameter int                 KEY_LEN     = 4,
  parameter logic [KEY_LEN-1:0] KEY_VALUE   = KEY_LEN'(DEFAULT_KEY_VALUE),
  parameter int                 MODE_W      = 1,
  parameter int                 MAX_FAILS   = 3,
  parameter int                 LOCKOUT_CYC = 16,
  parameter int                 TIMEOUT_CYC = 32
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             InputKey,
  input  logic                             ValidCmd,
  input  logic                             Busy,
  input  logic                             Clear,
  output logic                             Active,
  output logic [MODE_W-1:0]                Mode,
  output logic                             Locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   FailCount
);

  localparam int CNT_W  = cnt_width(KEY_LEN, MODE_W);
  localparam int SH_W   = (KEY_LEN > MODE_W) ? KEY_LEN : MODE_W;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  localparam logic [CNT_W-1:0]  KEY_LAST  = CNT_W'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0]  MODE_LAST = CNT_W'(MODE_W - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);

  state_t              state, state_n;
  logic [SH_W-1:0]     shreg, shreg_n;
  logic [SH_W:0]       shifted;
  logic [CNT_W-1:0]    bitcnt, bitcnt_n;
  logic [FAIL_W-1:0]   fail_n;
  logic [MODE_W-1:0]   mode_n;
  logic                tmo_load, tmo_done;
  logic                lock_load, lock_done;

  assign shifted = {shreg, InputKey};

  dec_key_timer #(.CYCLES(TIMEOUT_CYC)) u_tmo_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (tmo_load),
    .done  (tmo_done)
  );

  dec_key_timer #(.CYCLES(LOCKOUT_CYC)) u_lock_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (lock_load),
    .done  (lock_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    fail_n    = FailCount;
    mode_n    = Mode;
    tmo_load  = 1'b0;
    lock_load = 1'b0;

    unique case (state)
      // IDLE shares the key path: its bit counter is zero, so the first strobe is bit one.
      // Clear while IDLE is a no-op, so a coincident strobe still starts an attempt.
      S_IDLE, S_KEY: begin
        if (Clear && state == S_KEY) begin
          state_n  = S_IDLE;
          shreg_n  = '0;
          bitcnt_n = '0;
        end else if (ValidCmd) begin
          shreg_n  = shifted[SH_W-1:0];
          tmo_load = 1'b1;
          if (bitcnt == KEY_LAST) begin
            bitcnt_n = '0;
            if (shifted[KEY_LEN-1:0] == KEY_VALUE) begin
              state_n = S_MODE;
              fail_n  = '0;
            end else if (FailCount == FAIL_LAST) begin
              state_n   = S_LOCKOUT;
              fail_n    = '0;
              lock_load = 1'b1;
              shreg_n   = '0;
            end else begin
              state_n = S_IDLE;
              fail_n  = FailCount + FAIL_W'(1);
              shreg_n = '0;
            end
          end else begin
            bitcnt_n = bitcnt + CNT_W'(1);
            state_n  = S_KEY;
          end
        end else if (state == S_KEY && tmo_done) begin
          state_n  = S_IDLE;
          shreg_n  = '0;
          bitcnt_n = '0;
        end
      end

      S_MODE: begin
        if (Clear) begin
          state_n  = S_IDLE;
          shreg_n  = '0;
          bitcnt_n = '0;
        end else if (ValidCmd) begin
          shreg_n  = shifted[SH_W-1:0];
          tmo_load = 1'b1;
          if (bitcnt == MODE_LAST) begin
            bitcnt_n = '0;
            state_n  = S_ARMED;
          end else begin
            bitcnt_n = bitcnt + CNT_W'(1);
          end
        end else if (tmo_done) begin
          state_n  = S_IDLE;
          shreg_n  = '0;
          bitcnt_n = '0;
        end
      end

      S_ARMED: begin
        if (Clear) begin
          state_n = S_IDLE;
          shreg_n = '0;
        end else if (!Busy) begin
          state_n = S_ACTIVE;
          mode_n  = shreg[MODE_W-1:0];
        end
      end

      S_ACTIVE: begin
        if (Clear) begin
          state_n = S_IDLE;
          mode_n  = '0;
          shreg_n = '0;
        end
      end

      S_LOCKOUT: begin
        if (lock_done) state_n = S_IDLE;
      end

      default: begin
        state_n  = S_IDLE;
        shreg_n  = '0;
        bitcnt_n = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      FailCount <= '0;
      Active    <= 1'b0;
      Mode      <= '0;
      Locked    <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      FailCount <= fail_n;
      Active    <= (state_n == S_ACTIVE);
      Mode      <= mode_n;
      Locked    <= (state_n == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_dec_input_key_seq.sv
// Bench for dec_input_key_seq: two configurations checked every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_dec_input_key_seq;

  localparam int P_IDLE = 0, P_KEY = 1, P_MODE = 2, P_ARMED = 3, P_ACTIVE = 4, P_LOCK = 5;

  // Index 0: default configuration; index 1: 6-bit key, 2-bit mode, two fails.
  int kl  [2] = '{4, 6};
  int kv  [2] = '{'b1010, 'b110010};
  int mw  [2] = '{1, 2};
  int mf  [2] = '{3, 2};
  int lc  [2] = '{16, 16};
  int tmo [2] = '{32, 32};

  logic Clk;
  logic Reset;
  logic in_key [2];
  logic valid  [2];
  logic busy   [2];
  logic clear  [2];
  logic act    [2];
  logic lck    [2];
  logic [0:0] mode0;
  logic [1:0] mode1;
  logic [1:0] fc0;
  logic [1:0] fc1;

  int vectors;
  int miscompares;

  int m_phase [2];
  int m_word  [2];
  int m_nbits [2];
  int m_idle  [2];
  int m_fails [2];
  int m_mode  [2];
  int m_left  [2];

  dec_input_key_seq dut_a (
    .Clk(Clk), .Reset(Reset), .InputKey(in_key[0]), .ValidCmd(valid[0]),
    .Busy(busy[0]), .Clear(clear[0]), .Active(act[0]), .Mode(mode0),
    .Locked(lck[0]), .FailCount(fc0)
  );

  dec_input_key_seq #(
    .KEY_LEN(6), .KEY_VALUE(6'b110010), .MODE_W(2), .MAX_FAILS(2)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .InputKey(in_key[1]), .ValidCmd(valid[1]),
    .Busy(busy[1]), .Clear(clear[1]), .Active(act[1]), .Mode(mode1),
    .Locked(lck[1]), .FailCount(fc1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset(input int i);
    m_phase[i] = P_IDLE; m_word[i] = 0; m_nbits[i] = 0; m_idle[i] = 0;
    m_fails[i] = 0; m_mode[i] = 0; m_left[i] = 0;
  endtask

  task automatic go_idle(input int i);
    m_phase[i] = P_IDLE; m_word[i] = 0; m_nbits[i] = 0;
  endtask

  task automatic key_done(input int i);
    if (m_word[i] == kv[i]) begin
      m_phase[i] = P_MODE; m_word[i] = 0; m_nbits[i] = 0; m_fails[i] = 0;
    end else if (m_fails[i] + 1 == mf[i]) begin
      go_idle(i);
      m_phase[i] = P_LOCK; m_fails[i] = 0; m_left[i] = lc[i];
    end else begin
      m_fails[i]++;
      go_idle(i);
    end
  endtask

  task automatic model_step(input int i);
    int b;
    b = int'(in_key[i]);
    case (m_phase[i])
      P_IDLE: if (valid[i]) begin
        m_word[i] = b; m_nbits[i] = 1; m_idle[i] = 0; m_phase[i] = P_KEY;
        if (m_nbits[i] == kl[i]) key_done(i);
      end
      P_KEY, P_MODE: begin
        if (clear[i]) go_idle(i);
        else if (valid[i]) begin
          m_word[i] = m_word[i] * 2 + b; m_nbits[i]++; m_idle[i] = 0;
          if (m_phase[i] == P_KEY && m_nbits[i] == kl[i]) key_done(i);
          else if (m_phase[i] == P_MODE && m_nbits[i] == mw[i]) m_phase[i] = P_ARMED;
        end else begin
          m_idle[i]++;
          if (m_idle[i] == tmo[i]) go_idle(i);
        end
      end
      P_ARMED: begin
        if (clear[i]) go_idle(i);
        else if (!busy[i]) begin m_phase[i] = P_ACTIVE; m_mode[i] = m_word[i]; end
      end
      P_ACTIVE: if (clear[i]) begin go_idle(i); m_mode[i] = 0; end
      P_LOCK: begin
        m_left[i]--;
        if (m_left[i] == 0) go_idle(i);
      end
      default: go_idle(i);
    endcase
  endtask

  always @(posedge Clk or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) model_reset(i);
      else       model_step(i);
    end
  end

  always @(negedge Clk) begin
    check("cmp_a_active", act[0], (m_phase[0] == P_ACTIVE));
    check("cmp_a_locked", lck[0], (m_phase[0] == P_LOCK));
    check("cmp_a_mode",   mode0,  m_mode[0]);
    check("cmp_a_fails",  fc0,    m_fails[0]);
    check("cmp_b_active", act[1], (m_phase[1] == P_ACTIVE));
    check("cmp_b_locked", lck[1], (m_phase[1] == P_LOCK));
    check("cmp_b_mode",   mode1,  m_mode[1]);
    check("cmp_b_fails",  fc1,    m_fails[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Sends n bits MSB first; gap>0 inserts up to gap random idle cycles after each bit.
  task automatic send_bits(input int i, input logic [31:0] v, input int n, input int gap);
    int g;
    for (int j = n - 1; j >= 0; j--) begin
      @(negedge Clk);
      valid[i] = 1'b1; in_key[i] = v[j];
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      repeat (g) begin
        @(negedge Clk);
        valid[i] = 1'b0; in_key[i] = 1'($urandom_range(1, 0));
      end
    end
    @(negedge Clk);
    valid[i] = 1'b0;
  endtask

  task automatic pulse_clear(input int i);
    @(negedge Clk); clear[i] = 1'b1;
    @(negedge Clk); clear[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic rand_run(input int i, input int iters);
    for (int k = 0; k < iters; k++) begin
      int a;
      a = int'($urandom_range(9, 0));
      busy[i] = ($urandom_range(3, 0) == 0);
      case (a)
        0, 1, 2, 3: send_bits(i, (kv[i] << mw[i]) | int'($urandom_range((1 << mw[i]) - 1, 0)),
                              kl[i] + mw[i], (a == 3) ? 3 : 0);
        4, 5: send_bits(i, $urandom, int'($urandom_range(kl[i], 1)), 1);
        6: repeat ($urandom_range(40, 1)) begin
             @(negedge Clk);
             busy[i] = ($urandom_range(1, 0) == 0);
           end
        7: begin
             @(negedge Clk);
             clear[i] = 1'b1; valid[i] = 1'($urandom_range(1, 0));
             in_key[i] = 1'($urandom_range(1, 0));
             @(negedge Clk);
             clear[i] = 1'b0; valid[i] = 1'b0;
           end
        8: send_bits(i, kv[i] << mw[i], kl[i] + mw[i], 40);
        default: if ($urandom_range(3, 0) == 0) do_reset(); else idle(2);
      endcase
    end
    busy[i] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 2; i++) begin
      in_key[i] = 1'b0; valid[i] = 1'b0; busy[i] = 1'b0; clear[i] = 1'b0;
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst_active", act[0], 0);
    check("rst_locked", lck[0], 0);
    check("rst_mode",   mode0,  0);
    check("rst_fails",  fc0,    0);

    // Correct key 1010 + mode 1, Busy low.
    send_bits(0, 5'b10101, 5, 0);
    check("t1_armed_not_active", act[0], 0);
    idle(1);
    check("t1_active", act[0], 1);
    check("t1_mode",   mode0,  1);
    check("t1_locked", lck[0], 0);
    check("t1_fails",  fc0,    0);

    // Clear with a coincident strobe: relock, bit dropped.
    @(negedge Clk); clear[0] = 1'b1; valid[0] = 1'b1; in_key[0] = 1'b1;
    @(negedge Clk); clear[0] = 1'b0; valid[0] = 1'b0;
    check("t6_active", act[0], 0);
    check("t6_mode",   mode0,  0);
    send_bits(0, 5'b10101, 5, 0);
    idle(1);
    check("t6_bit_dropped", act[0], 1);
    pulse_clear(0);

    // Busy holds off activation.
    busy[0] = 1'b1;
    send_bits(0, 5'b10101, 5, 0);
    idle(10);
    check("t2_busy_blocks", act[0], 0);
    busy[0] = 1'b0;
    idle(1);
    check("t2_active", act[0], 1);
    check("t2_mode",   mode0,  1);
    pulse_clear(0);

    // Three wrong keys -> lockout of 16 cycles; key ignored during lockout.
    send_bits(0, 4'b1111, 4, 0);
    check("t3_fail1", fc0, 1);
    send_bits(0, 4'b1111, 4, 0);
    check("t3_fail2", fc0, 2);
    send_bits(0, 4'b1111, 4, 0);
    check("t3_locked", lck[0], 1);
    check("t3_fail_reset", fc0, 0);
    send_bits(0, 5'b10101, 5, 0);
    idle(9);
    check("t3_still_locked", lck[0], 1);
    check("t3_ignored", act[0], 0);
    idle(1);
    check("t3_unlocked", lck[0], 0);
    send_bits(0, 5'b10101, 5, 0);
    idle(1);
    check("t3_after_lockout", act[0], 1);
    pulse_clear(0);

    // Timeout boundary: 31 idle cycles still continues, 32 aborts.
    send_bits(0, 2'b10, 2, 0);
    idle(30);
    send_bits(0, 3'b101, 3, 0);
    idle(1);
    check("t4_within_timeout", act[0], 1);
    pulse_clear(0);
    send_bits(0, 2'b10, 2, 0);
    idle(31);
    send_bits(0, 3'b101, 3, 0);
    idle(1);
    check("t4_timed_out", act[0], 0);
    idle(40);
    check("t4_fails_unchanged", fc0, 0);
    check("t4_not_locked", lck[0], 0);

    // Reset mid-attempt; no carry-over of partial bits.
    send_bits(0, 3'b101, 3, 0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check("t5_reset_active", act[0], 0);
    check("t5_reset_fails", fc0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    send_bits(0, 5'b10100, 5, 0);
    idle(1);
    check("t5_active", act[0], 1);
    check("t5_mode0",  mode0,  0);
    pulse_clear(0);

    // Second configuration: key 110010, mode 10, two fails to lockout.
    send_bits(1, 8'b11001010, 8, 0);
    idle(1);
    check("t7_active", act[1], 1);
    check("t7_mode",   mode1,  2);
    pulse_clear(1);
    send_bits(1, 6'b111111, 6, 0);
    check("t7_fail1", fc1, 1);
    send_bits(1, 6'b111111, 6, 0);
    check("t7_locked", lck[1], 1);
    check("t7_fail_reset", fc1, 0);
    idle(15);
    check("t7_still_locked", lck[1], 1);
    idle(1);
    check("t7_unlocked", lck[1], 0);
    send_bits(1, 8'b11001001, 8, 0);
    idle(1);
    check("t7_after_lockout", act[1], 1);
    check("t7_mode_b",        mode1,  1);
    pulse_clear(1);

    rand_run(0, 150);
    rand_run(1, 150);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
